// File: rtl/sn74ls163a_ctr_if.sv
// Control/data bundle for the sn74ls163a_ctr counter; clk and clr_n stay plain ports on the counter.
interface sn74ls163a_ctr_if #(parameter int WIDTH = 4);
  logic             ld_n;
  logic             enp;
  logic             ent;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;
  logic             rco;

  modport master (output ld_n, enp, ent, d, input  q, rco);
  modport slave  (input  ld_n, enp, ent, d, output q, rco);
endinterface

// File: rtl/sn74ls163a_ctr.sv
// SN74LS163A-style synchronous binary counter: sync clear > sync load > count (enp & ent) > hold.
// Define SN74LS163A_ASSERT_EN to compile simulation-only protocol/behaviour checks.
module sn74ls163a_ctr #(
  parameter int WIDTH = 4
) (
  input  logic          clk,
  input  logic          clr_n,
  sn74ls163a_ctr_if.slave bus
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  // Clear lives in the flop process; load/count/hold are resolved here.
  always_comb begin
    q_d = q_q;
    if (!bus.ld_n)
      q_d = bus.d;
    else if (bus.enp && bus.ent)
      q_d = q_q + WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (!clr_n) q_q <= '0;
    else        q_q <= q_d;
  end

  assign bus.q   = q_q;
  // Terminal count is gated only by ent so cascaded stages see carry without enp.
  assign bus.rco = bus.ent & (&q_q);

`ifdef SN74LS163A_ASSERT_EN
  logic [WIDTH-1:0] chk_q_prev;
  logic             chk_clr_prev;
  logic             chk_ld_prev;
  logic             chk_cnt_prev;
  logic [WIDTH-1:0] chk_d_prev;
  logic             chk_armed;

  always @(posedge clk) begin
    assert (!$isunknown({clr_n, bus.ld_n, bus.enp, bus.ent}))
      else $error("sn74ls163a_ctr: X/Z on a control input at clk edge");
    assert ($isunknown(q_q) || bus.rco === (bus.ent & (&q_q)))
      else $error("sn74ls163a_ctr: rco inconsistent with ent and q");
    if (chk_armed && !chk_clr_prev && !$isunknown(chk_q_prev)) begin
      if (chk_ld_prev)
        assert (q_q === chk_d_prev) else $error("sn74ls163a_ctr: load did not take d");
      else if (chk_cnt_prev)
        assert (q_q === chk_q_prev + WIDTH'(1)) else $error("sn74ls163a_ctr: increment is not +1");
      else
        assert (q_q === chk_q_prev) else $error("sn74ls163a_ctr: q changed with no clear/load/count");
    end
    chk_armed    <= 1'b1;
    chk_q_prev   <= q_q;
    chk_clr_prev <= !clr_n;
    chk_ld_prev  <= !bus.ld_n;
    chk_cnt_prev <= bus.enp && bus.ent;
    chk_d_prev   <= bus.d;
  end
`else
  // Checks compiled out; counter behaviour is unchanged.
`endif

endmodule

// File: tb/tb_sn74ls163a_ctr.sv
// Directed-vector bench for sn74ls163a_ctr with hand-computed expected q/rco values.
module tb_sn74ls163a_ctr;
  localparam int WIDTH = 4;

  logic clk = 1'b0;
  logic clr_n;
  int   vectors = 0;
  int   miscompares = 0;

  sn74ls163a_ctr_if #(.WIDTH(WIDTH)) bus ();
  sn74ls163a_ctr #(.WIDTH(WIDTH)) dut (.clk(clk), .clr_n(clr_n), .bus(bus));

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp)
      else begin
        miscompares++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  task automatic chk_qr(input string tag, input logic [3:0] eq, input logic er);
    chk({tag, ".q"},   {4'h0, bus.q}, {4'h0, eq});
    chk({tag, ".rco"}, {7'h0, bus.rco}, {7'h0, er});
  endtask

  initial begin
    logic [3:0] seq [8];
    seq = '{4'hB, 4'hC, 4'hD, 4'hE, 4'hF, 4'h0, 4'h1, 4'h2};

    clr_n = 1'b1; bus.ld_n = 1'b1; bus.enp = 1'b0; bus.ent = 1'b0; bus.d = '0;
    step(); step();

    // T1: load an arbitrary value, then clear it
    bus.ld_n = 1'b0; bus.d = 4'h6;
    step(); chk_qr("t1_preload", 4'h6, 1'b0);
    bus.ld_n = 1'b1; clr_n = 1'b0; bus.ent = 1'b1;
    step(); chk_qr("t1_clear", 4'h0, 1'b0);
    clr_n = 1'b1; bus.ent = 1'b0;

    // T2: load 1010, then hold with enables low
    bus.ld_n = 1'b0; bus.d = 4'hA;
    step(); chk_qr("t2_load", 4'hA, 1'b0);
    bus.ld_n = 1'b1;
    step(); chk_qr("t2_hold", 4'hA, 1'b0);

    // T3: count 8 edges through the wrap
    bus.enp = 1'b1; bus.ent = 1'b1;
    #1 chk_qr("t3_pre", 4'hA, 1'b0);
    for (int i = 0; i < 8; i++) begin
      step();
      chk_qr($sformatf("t3_cnt%0d", i), seq[i], seq[i] == 4'hF);
    end

    // T4: enp low holds; load all-ones with ent high raises rco
    bus.enp = 1'b0;
    step(); chk_qr("t4_hold0", 4'h2, 1'b0);
    step(); chk_qr("t4_hold1", 4'h2, 1'b0);
    bus.ld_n = 1'b0; bus.d = 4'hF;
    #1 chk_qr("t4_preload", 4'h2, 1'b0);
    step(); chk_qr("t4_loadF", 4'hF, 1'b1);
    bus.ld_n = 1'b1;
    step(); chk_qr("t4_holdF", 4'hF, 1'b1);

    // T5: ent drop kills rco immediately; enp=1 ent=0 holds
    bus.ent = 1'b0;
    #1 chk_qr("t5_ent_drop", 4'hF, 1'b0);
    bus.enp = 1'b1;
    step(); chk_qr("t5_hold", 4'hF, 1'b0);

    // T6: clear beats load on the same edge
    clr_n = 1'b0; bus.ld_n = 1'b0; bus.d = 4'h5;
    step(); chk_qr("t6_clr_wins", 4'h0, 1'b0);

    // Mid-count clear, then resume from 1
    clr_n = 1'b1; bus.ld_n = 1'b1; bus.enp = 1'b1; bus.ent = 1'b1;
    step(); chk_qr("mc_cnt1", 4'h1, 1'b0);
    step(); chk_qr("mc_cnt2", 4'h2, 1'b0);
    clr_n = 1'b0;
    step(); chk_qr("mc_clear", 4'h0, 1'b0);
    clr_n = 1'b1;
    step(); chk_qr("mc_resume", 4'h1, 1'b0);

    // Load pulse that ends before the edge has no effect
    bus.enp = 1'b0; bus.ent = 1'b0;
    step(); chk_qr("glitch_base", 4'h1, 1'b0);
    bus.ld_n = 1'b0; bus.d = 4'h9;
    #2 bus.ld_n = 1'b1;
    step(); chk_qr("glitch_hold", 4'h1, 1'b0);

    // enp=0 ent=1 at all-ones: hold, rco stays high
    bus.ld_n = 1'b0; bus.d = 4'hF;
    step(); bus.ld_n = 1'b1; bus.ent = 1'b1;
    #1 chk_qr("f_ent_only", 4'hF, 1'b1);
    step(); chk_qr("f_hold", 4'hF, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
